// File: rtl/rr_sel_arb4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_sel_arb4
//  Brief    : Four-requester round-robin arbiter producing a registered
//             one-hot grant, a 2-bit mux select and a valid/ready handshake.
//             The requester served last gets the lowest priority next time.
//  Options  : RR_SEL_ARB4_LOCK_EN - when defined, a handshake with lock=1
//             and the winner still requesting keeps the current grant
//             (burst hold). When undefined, lock is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_sel_arb4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       lock,
    input  logic       ready,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       valid,
    output logic [1:0] last
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [3:0] r_grant;
    logic [3:0] w_grant_nxt;
    logic [1:0] r_sel;
    logic [1:0] w_sel_nxt;
    logic       r_valid;
    logic       w_valid_nxt;
    logic [1:0] r_last;
    logic [1:0] w_last_nxt;

    logic       w_hs;
    logic       w_hold;
    logic [3:0] w_mask;

    // First set channel scanning base+1 .. base+4 (mod 4). The loop walks
    // from the farthest offset down so the nearest hit overwrites last.
    function automatic logic [1:0] f_pick(input logic [3:0] mask,
                                          input logic [1:0] base);
        logic [1:0] idx;
        logic [1:0] win;
        win = base;
        for (int k = 4; k >= 1; k--) begin
            idx = base + k[1:0];
            if (mask[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

    function automatic logic [3:0] f_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

`ifdef RR_SEL_ARB4_LOCK_EN
    // Burst hold: winner keeps the bus while it asserts lock and still requests.
    assign w_hold = lock & req[r_sel];
`else
    // lock is present on the port for pin compatibility only.
    logic w_unused_lock;
    assign w_unused_lock = lock;
    assign w_hold        = 1'b0;
`endif

    assign w_hs   = r_valid & ready;
    // The channel completing now is excluded for this one arbitration.
    assign w_mask = req & ~r_grant;

    // Next-state and next-output selection for the IDLE/BUSY machine.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_sel_nxt   = f_pick(req, r_last);
                    w_grant_nxt = f_onehot(w_sel_nxt);
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_hs && !w_hold) begin
                    w_last_nxt = r_sel;
                    if (|w_mask) begin
                        // Rotate from the channel that just completed: no bubble.
                        w_sel_nxt   = f_pick(w_mask, r_sel);
                        w_grant_nxt = f_onehot(w_sel_nxt);
                    end else begin
                        w_sel_nxt   = 2'd0;
                        w_grant_nxt = 4'b0000;
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_sel_nxt   = 2'd0;
                w_grant_nxt = 4'b0000;
                w_valid_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears outputs without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= 4'b0000;
            r_sel   <= 2'd0;
            r_valid <= 1'b0;
            r_last  <= 2'd3;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign grant = r_grant;
    assign sel   = r_sel;
    assign valid = r_valid;
    assign last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_rr_sel_arb4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_sel_arb4
//  Brief    : Self-checking bench for rr_sel_arb4 with directed scenarios and
//             randomized traffic compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_sel_arb4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       lock;
    logic       ready;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic [1:0] last;

    int errors = 0;
    int checks = 0;

    // Behavioural model: busy flag, index being served, last completed index.
    int m_busy;
    int m_sel;
    int m_last;

`ifdef RR_SEL_ARB4_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    rr_sel_arb4 dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .lock  (lock),
        .ready (ready),
        .grant (grant),
        .sel   (sel),
        .valid (valid),
        .last  (last)
    );

    always #5 clk = ~clk;

    // Round-robin rule: first requesting channel after 'base', wrapping.
    function automatic int pick(input logic [3:0] mask, input int base);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(base + k) % 4]) return (base + k) % 4;
        end
        return 0;
    endfunction

    function automatic logic [8:0] model_vec();
        logic [3:0] g;
        logic [1:0] s;
        logic [1:0] l;
        g = 4'b0000;
        if (m_busy != 0) g[m_sel] = 1'b1;
        s = m_sel[1:0];
        l = m_last[1:0];
        return {g, s, (m_busy != 0), l};
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_sel  = 0;
        m_last = 3;
    endtask

    // Apply one rising edge of the specification rules to the model.
    task automatic model_update();
        logic [3:0] msk;
        if (rst) begin
            model_reset();
        end else if (m_busy == 0) begin
            if (req != 4'b0000) begin
                m_sel  = pick(req, m_last);
                m_busy = 1;
            end
        end else if (ready) begin
            if (LOCK_EN && lock && req[m_sel]) begin
                // burst continues on the same channel
            end else begin
                m_last = m_sel;
                msk = req;
                msk[m_sel] = 1'b0;
                if (msk != 4'b0000) begin
                    m_sel = pick(msk, m_last);
                end else begin
                    m_busy = 0;
                    m_sel  = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic go_idle();
        int n;
        req   = 4'b0000;
        ready = 1'b1;
        lock  = 1'b0;
        n = 0;
        while (valid === 1'b1 && n < 8) begin
            step();
            n++;
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL go_idle_timeout: valid=%b after %0d cycles, required 0", valid, n);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        req   = 4'b1111;
        ready = 1'b0;
        lock  = 1'b0;
        model_reset();
        step();
        step();
        checks++;
        if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++;
        if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++;
        if (last !== 2'd3) begin errors++; $display("FAIL reset_last: got %0d want 3", last); end
        rst = 1'b0;
        step();
        checks++;
        if ({grant, sel, valid} !== {4'b0001, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_first_grant: grant=%b sel=%0d valid=%b want 0001/0/1", grant, sel, valid);
        end
    endtask

    task automatic test_rotation();
        int exp_sel[4] = '{1, 2, 3, 0};
        // Continues from the first grant (channel 0) after reset.
        req   = 4'b1111;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (sel !== exp_sel[i][1:0] || valid !== 1'b1) begin
                errors++;
                $display("FAIL rotation_%0d: sel=%0d valid=%b want sel=%0d valid=1", i, sel, valid, exp_sel[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        go_idle();
        req   = 4'b0100;
        ready = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({grant, sel, valid} !== {4'b0100, 2'd2, 1'b1}) begin
                errors++;
                $display("FAIL backpressure_%0d: grant=%b sel=%0d valid=%b want 0100/2/1", i, grant, sel, valid);
            end
            if (i < 5) begin
                if (i == 2) req = 4'b0000;  // deassert while stalled: ignored
                step();
            end
        end
        ready = 1'b1;
        req   = 4'b0000;
        step();
        checks++;
        if ({grant, valid, last} !== {4'b0000, 1'b0, 2'd2}) begin
            errors++;
            $display("FAIL backpressure_done: grant=%b valid=%b last=%0d want 0000/0/2", grant, valid, last);
        end
    endtask

    task automatic test_single_repeat();
        go_idle();
        req   = 4'b1000;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (valid !== ((i % 2) == 0) || (valid === 1'b1 && sel !== 2'd3)) begin
                errors++;
                $display("FAIL single_repeat_%0d: valid=%b sel=%0d want valid=%0d sel=3", i, valid, sel, (i % 2) == 0);
            end
        end
    endtask

    task automatic test_async_reset();
        go_idle();
        req   = 4'b0010;
        ready = 1'b0;
        step();
        checks++;
        if ({sel, valid} !== {2'd1, 1'b1}) begin
            errors++;
            $display("FAIL async_setup: sel=%0d valid=%b want 1/1", sel, valid);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({grant, sel, valid, last} !== {4'b0000, 2'd0, 1'b0, 2'd3}) begin
            errors++;
            $display("FAIL async_reset_clear: grant=%b sel=%0d valid=%b last=%0d want 0000/0/0/3", grant, sel, valid, last);
        end
        #1;
        rst = 1'b0;
        req = 4'b0110;
        step();
        checks++;
        if ({grant, sel, valid} !== {4'b0010, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL async_regrant: grant=%b sel=%0d valid=%b want 0010/1/1", grant, sel, valid);
        end
    endtask

    task automatic test_lock();
        int exp_lock[5]   = '{0, 0, 0, 0, 1};
        int exp_nolock[5] = '{0, 1, 0, 1, 0};
        int e;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        req   = 4'b0011;
        ready = 1'b1;
        lock  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            // edge 0 grants; edges 1..3 are locked handshakes; edge 4 unlocked
            lock = (i < 4);
            step();
            e = LOCK_EN ? exp_lock[i] : exp_nolock[i];
            checks++;
            if (sel !== e[1:0] || valid !== 1'b1) begin
                errors++;
                $display("FAIL lock_seq_%0d: sel=%0d valid=%b want sel=%0d valid=1", i, sel, valid, e);
            end
        end
        lock = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req   = 4'($urandom_range(0, 15));
            ready = ($urandom_range(0, 3) != 0);
            lock  = ($urandom_range(0, 1) == 1);
            step();
            checks++;
            if ({grant, sel, valid, last} !== model_vec()) begin
                errors++;
                $display("FAIL random_%0d: {grant,sel,valid,last}=%b want %b", i, {grant, sel, valid, last}, model_vec());
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = 4'b0000;
        ready = 1'b0;
        lock  = 1'b0;
        model_reset();
        test_reset();
        test_rotation();
        test_backpressure();
        test_single_repeat();
        test_async_reset();
        test_lock();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
